// File: rtl/image_crop.sv
// image_crop: keeps a rectangular window of a tagged pixel stream, 1-clk latency
// Ports: clk/reset (sync, active-high); enable, row_offset, col_offset, win_rows,
// win_cols are shadowed at FRAME_START; dvi/dtypei/datai in, dvo/dtypeo/datao out;
// out_rows/out_cols report the geometry of the last completed frame.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`define DTYPE_FRAME_START  4'h1
`define DTYPE_FRAME_END    4'h2
`define DTYPE_ROW_START    4'h3
`define DTYPE_ROW_END      4'h4
`define DTYPE_PIXEL        4'h5
`define DTYPE_HEADER_START 4'h6
`define DTYPE_HEADER       4'h7
`define DTYPE_HEADER_END   4'h8
`endif
module image_crop #(
  parameter int DATA_WIDTH = 16,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [DIM_WIDTH-1:0]    row_offset,
  input  logic [DIM_WIDTH-1:0]    col_offset,
  input  logic [DIM_WIDTH-1:0]    win_rows,
  input  logic [DIM_WIDTH-1:0]    win_cols,
  input  logic                    dvi,
  input  logic [`DTYPE_WIDTH-1:0] dtypei,
  input  logic [DATA_WIDTH-1:0]   datai,
  output logic                    dvo,
  output logic [`DTYPE_WIDTH-1:0] dtypeo,
  output logic [DATA_WIDTH-1:0]   datao,
  output logic [DIM_WIDTH-1:0]    out_rows,
  output logic [DIM_WIDTH-1:0]    out_cols
);
  localparam logic [`DTYPE_WIDTH-1:0] DT_FS = `DTYPE_FRAME_START;
  localparam logic [`DTYPE_WIDTH-1:0] DT_FE = `DTYPE_FRAME_END;
  localparam logic [`DTYPE_WIDTH-1:0] DT_RS = `DTYPE_ROW_START;
  localparam logic [`DTYPE_WIDTH-1:0] DT_RE = `DTYPE_ROW_END;
  localparam logic [`DTYPE_WIDTH-1:0] DT_PX = `DTYPE_PIXEL;
  localparam logic [`DTYPE_WIDTH-1:0] DT_HS = `DTYPE_HEADER_START;
  localparam logic [`DTYPE_WIDTH-1:0] DT_HD = `DTYPE_HEADER;
  localparam logic [`DTYPE_WIDTH-1:0] DT_HE = `DTYPE_HEADER_END;
  typedef enum logic {WAIT_FRAME, IN_FRAME} state_e;
  state_e st_q, st_d;
  logic en_q, en_d, in_row_q, in_row_d, dv_q, dv_d;
  logic [DIM_WIDTH-1:0] roff_q, roff_d, coff_q, coff_d, wrows_q, wrows_d, wcols_q, wcols_d;
  logic [DIM_WIDTH-1:0] row_cnt_q, row_cnt_d, col_cnt_q, col_cnt_d;
  logic [DIM_WIDTH-1:0] orow_q, orow_d, ocol_q, ocol_d, owidth_q, owidth_d;
  logic [DIM_WIDTH-1:0] out_rows_q, out_rows_d, out_cols_q, out_cols_d;
  logic [`DTYPE_WIDTH-1:0] dt_q, dt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DIM_WIDTH-1:0] rel_row, col, rel_col, ocol_base;
  logic row_win, pix_win, row_done, is_hdr;
  function automatic logic [DIM_WIDTH-1:0] sat_inc(input logic [DIM_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction
  // With cropping disabled the window covers everything, so the raw counts
  // fall out of the same row/column bookkeeping.
  assign rel_row = row_cnt_q - roff_q;
  assign row_win = !en_q || (row_cnt_q >= roff_q && (wrows_q == '0 || rel_row < wrows_q));
  assign col = in_row_q ? col_cnt_q : '0;
  assign rel_col = col - coff_q;
  assign pix_win = row_win && (!en_q || (col >= coff_q && (wcols_q == '0 || rel_col < wcols_q)));
  // A pixel outside a row is an implicit row start; in the window it restarts the width count.
  assign ocol_base = (!in_row_q && row_win) ? '0 : ocol_q;
  assign row_done = in_row_q && row_win && ocol_q != '0;
  assign is_hdr = dtypei == DT_HS || dtypei == DT_HD || dtypei == DT_HE;
  always_comb begin
    st_d = st_q;
    en_d = en_q;
    roff_d = roff_q;
    coff_d = coff_q;
    wrows_d = wrows_q;
    wcols_d = wcols_q;
    in_row_d = in_row_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    orow_d = orow_q;
    ocol_d = ocol_q;
    owidth_d = owidth_q;
    out_rows_d = out_rows_q;
    out_cols_d = out_cols_q;
    dv_d = 1'b0;
    dt_d = '0;
    data_d = '0;
    if (dvi) begin
      if (dtypei == DT_FS) begin
        st_d = IN_FRAME;
        en_d = enable;
        roff_d = row_offset;
        coff_d = col_offset;
        wrows_d = win_rows;
        wcols_d = win_cols;
        in_row_d = 1'b0;
        row_cnt_d = '0;
        col_cnt_d = '0;
        orow_d = '0;
        ocol_d = '0;
        owidth_d = '0;
        dv_d = 1'b1;
        dt_d = dtypei;
        data_d = datai;
      end else if (st_q == WAIT_FRAME) begin
        dv_d = is_hdr;
        dt_d = is_hdr ? dtypei : '0;
        data_d = is_hdr ? datai : '0;
      end else begin
        case (dtypei)
          DT_PX: begin
            in_row_d = 1'b1;
            col_cnt_d = sat_inc(col);
            ocol_d = pix_win ? sat_inc(ocol_base) : ocol_base;
            dv_d = pix_win;
            dt_d = pix_win ? dtypei : '0;
            data_d = pix_win ? datai : '0;
          end
          DT_RS: begin
            in_row_d = 1'b1;
            col_cnt_d = '0;
            ocol_d = '0;
            dv_d = row_win;
            dt_d = row_win ? dtypei : '0;
            data_d = !row_win ? '0 : en_q ? DATA_WIDTH'(rel_row) : datai;
          end
          DT_RE: begin
            in_row_d = 1'b0;
            row_cnt_d = in_row_q ? sat_inc(row_cnt_q) : row_cnt_q;
            ocol_d = in_row_q ? '0 : ocol_q;
            orow_d = row_done ? sat_inc(orow_q) : orow_q;
            owidth_d = row_done ? ocol_q : owidth_q;
            dv_d = row_win;
            dt_d = row_win ? dtypei : '0;
            data_d = (row_win && !en_q) ? datai : '0;
          end
          DT_FE: begin
            st_d = WAIT_FRAME;
            in_row_d = 1'b0;
            row_cnt_d = in_row_q ? sat_inc(row_cnt_q) : row_cnt_q;
            out_rows_d = row_done ? sat_inc(orow_q) : orow_q;
            out_cols_d = row_done ? ocol_q : owidth_q;
            dv_d = 1'b1;
            dt_d = dtypei;
            data_d = datai;
          end
          default: begin
            dv_d = 1'b1;
            dt_d = dtypei;
            data_d = datai;
          end
        endcase
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= WAIT_FRAME;
      en_q <= 1'b0;
      roff_q <= '0;
      coff_q <= '0;
      wrows_q <= '0;
      wcols_q <= '0;
      in_row_q <= 1'b0;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      orow_q <= '0;
      ocol_q <= '0;
      owidth_q <= '0;
      out_rows_q <= '0;
      out_cols_q <= '0;
      dv_q <= 1'b0;
      dt_q <= '0;
      data_q <= '0;
    end else begin
      st_q <= st_d;
      en_q <= en_d;
      roff_q <= roff_d;
      coff_q <= coff_d;
      wrows_q <= wrows_d;
      wcols_q <= wcols_d;
      in_row_q <= in_row_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      orow_q <= orow_d;
      ocol_q <= ocol_d;
      owidth_q <= owidth_d;
      out_rows_q <= out_rows_d;
      out_cols_q <= out_cols_d;
      dv_q <= dv_d;
      dt_q <= dt_d;
      data_q <= data_d;
    end
  end
  assign dvo = dv_q;
  assign dtypeo = dt_q;
  assign datao = data_q;
  assign out_rows = out_rows_q;
  assign out_cols = out_cols_q;
endmodule

// File: tb/tb_image_crop.sv
// tb_image_crop: directed self-checking bench for image_crop
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`define DTYPE_FRAME_START  4'h1
`define DTYPE_FRAME_END    4'h2
`define DTYPE_ROW_START    4'h3
`define DTYPE_ROW_END      4'h4
`define DTYPE_PIXEL        4'h5
`define DTYPE_HEADER_START 4'h6
`define DTYPE_HEADER       4'h7
`define DTYPE_HEADER_END   4'h8
`endif
module tb_image_crop;
  localparam int DW = 16;
  localparam int MW = 16;
  localparam int EW = 1 + `DTYPE_WIDTH + DW;
  localparam logic [`DTYPE_WIDTH-1:0] FS = `DTYPE_FRAME_START;
  localparam logic [`DTYPE_WIDTH-1:0] FE = `DTYPE_FRAME_END;
  localparam logic [`DTYPE_WIDTH-1:0] RS = `DTYPE_ROW_START;
  localparam logic [`DTYPE_WIDTH-1:0] RE = `DTYPE_ROW_END;
  localparam logic [`DTYPE_WIDTH-1:0] PX = `DTYPE_PIXEL;
  localparam logic [`DTYPE_WIDTH-1:0] HS = `DTYPE_HEADER_START;
  localparam logic [`DTYPE_WIDTH-1:0] HD = `DTYPE_HEADER;
  localparam logic [`DTYPE_WIDTH-1:0] HE = `DTYPE_HEADER_END;
  typedef struct {
    logic [`DTYPE_WIDTH-1:0] dt;
    logic [DW-1:0] d;
    logic [EW-1:0] e;
  } word_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [MW-1:0] row_offset = '0, col_offset = '0, win_rows = '0, win_cols = '0;
  logic dvi = 1'b0;
  logic [`DTYPE_WIDTH-1:0] dtypei = '0;
  logic [DW-1:0] datai = '0;
  logic dvo;
  logic [`DTYPE_WIDTH-1:0] dtypeo;
  logic [DW-1:0] datao;
  logic [MW-1:0] out_rows, out_cols;
  int pass_cnt = 0;
  int total_cnt = 0;
  always #5 clk = ~clk;
  image_crop #(.DATA_WIDTH(DW), .DIM_WIDTH(MW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .row_offset(row_offset), .col_offset(col_offset),
    .win_rows(win_rows), .win_cols(win_cols),
    .dvi(dvi), .dtypei(dtypei), .datai(datai),
    .dvo(dvo), .dtypeo(dtypeo), .datao(datao),
    .out_rows(out_rows), .out_cols(out_cols)
  );
  task automatic step(input logic v, input logic [`DTYPE_WIDTH-1:0] dt, input logic [DW-1:0] d);
    dvi = v;
    dtypei = dt;
    datai = d;
    @(posedge clk);
    #1;
    dvi = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    step(1'b1, FS, 16'h1234);
    step(1'b0, '0, '0);
    total_cnt++;
    if ({dvo, dtypeo, datao, out_rows, out_cols} !== '0)
      $display("FAIL reset_state: got dv=%b dt=%h d=%h rows=%0d cols=%0d, expected all zero", dvo, dtypeo, datao, out_rows, out_cols);
    else pass_cnt++;
    reset = 1'b0;
  endtask
  task automatic test_frame(input string name, input logic en, input int ro, input int co,
                            input int wr, input int wc, input int rows, input int cols,
                            input bit first_rs, input bit last_re, input int mid_wc,
                            input int exp_rows, input int exp_cols);
    word_t q[$];
    int chg = -1;
    bit rw, cw;
    logic [DW-1:0] d;
    logic [EW-1:0] got;
    q.push_back('{FS, 16'h00F0, {1'b1, FS, 16'h00F0}});
    for (int r = 0; r < rows; r++) begin
      if (r == rows / 2) chg = q.size();
      rw = !en || (r >= ro && (wr == 0 || r - ro < wr));
      if (r > 0 || first_rs)
        q.push_back('{RS, DW'(r), rw ? {1'b1, RS, en ? DW'(r - ro) : DW'(r)} : EW'(0)});
      for (int c = 0; c < cols; c++) begin
        cw = rw && (!en || (c >= co && (wc == 0 || c - co < wc)));
        d = DW'(16'h1000 + r * 16 + c);
        q.push_back('{PX, d, cw ? {1'b1, PX, d} : EW'(0)});
      end
      if (r < rows - 1 || last_re)
        q.push_back('{RE, 16'h00EE, rw ? {1'b1, RE, en ? 16'h0000 : 16'h00EE} : EW'(0)});
    end
    q.push_back('{FE, 16'h0F0F, {1'b1, FE, 16'h0F0F}});
    enable = en;
    row_offset = MW'(ro);
    col_offset = MW'(co);
    win_rows = MW'(wr);
    win_cols = MW'(wc);
    for (int i = 0; i < q.size(); i++) begin
      if (i == chg && mid_wc >= 0) begin
        win_cols = MW'(mid_wc);
        enable = ~en;
        row_offset = MW'(ro + 1);
      end
      step(1'b1, q[i].dt, q[i].d);
      got = {dvo, dtypeo, datao};
      total_cnt++;
      if (got !== q[i].e)
        $display("FAIL %s word %0d: got dv/dt/data %h, expected %h", name, i, got, q[i].e);
      else pass_cnt++;
    end
    total_cnt++;
    if (out_rows !== MW'(exp_rows) || out_cols !== MW'(exp_cols))
      $display("FAIL %s geometry: got %0dx%0d, expected %0dx%0d", name, out_rows, out_cols, exp_rows, exp_cols);
    else pass_cnt++;
  endtask
  task automatic test_header_wait();
    word_t q[$];
    logic [EW-1:0] got;
    q.push_back('{HS, 16'h00A1, {1'b1, HS, 16'h00A1}});
    q.push_back('{HD, 16'h1111, {1'b1, HD, 16'h1111}});
    q.push_back('{HD, 16'h2222, {1'b1, HD, 16'h2222}});
    q.push_back('{HD, 16'h3333, {1'b1, HD, 16'h3333}});
    q.push_back('{HE, 16'h00A2, {1'b1, HE, 16'h00A2}});
    q.push_back('{PX, 16'h5555, EW'(0)});
    q.push_back('{RS, 16'h0001, EW'(0)});
    q.push_back('{PX, 16'h6666, EW'(0)});
    q.push_back('{RE, 16'h0002, EW'(0)});
    for (int i = 0; i < q.size(); i++) begin
      step(1'b1, q[i].dt, q[i].d);
      got = {dvo, dtypeo, datao};
      total_cnt++;
      if (got !== q[i].e)
        $display("FAIL header_wait word %0d: got %h, expected %h", i, got, q[i].e);
      else pass_cnt++;
    end
    step(1'b0, HS, 16'hBEEF);
    total_cnt++;
    if ({dvo, dtypeo, datao} !== EW'(0))
      $display("FAIL dvi_low_ignored: got %h, expected 0", {dvo, dtypeo, datao});
    else pass_cnt++;
  endtask
  task automatic test_reset_midframe();
    int bad = 0;
    enable = 1'b1;
    row_offset = '0;
    col_offset = '0;
    win_rows = '0;
    win_cols = '0;
    step(1'b1, FS, 16'h0);
    for (int r = 0; r < 3; r++) begin
      step(1'b1, RS, DW'(r));
      for (int c = 0; c < 6; c++) step(1'b1, PX, DW'(c));
      step(1'b1, RE, 16'h0);
    end
    reset = 1'b1;
    step(1'b1, PX, 16'h7777);
    reset = 1'b0;
    total_cnt++;
    if ({dvo, dtypeo, datao, out_rows, out_cols} !== '0)
      $display("FAIL reset_midframe: got dv=%b dt=%h d=%h rows=%0d cols=%0d, expected all zero", dvo, dtypeo, datao, out_rows, out_cols);
    else pass_cnt++;
    for (int r = 3; r < 8; r++) begin
      step(1'b1, RS, DW'(r));
      bad += (dvo !== 1'b0 || dtypeo !== '0 || datao !== '0) ? 1 : 0;
      for (int c = 0; c < 6; c++) begin
        step(1'b1, PX, DW'(c));
        bad += (dvo !== 1'b0 || dtypeo !== '0 || datao !== '0) ? 1 : 0;
      end
      step(1'b1, RE, 16'h0);
      bad += (dvo !== 1'b0 || dtypeo !== '0 || datao !== '0) ? 1 : 0;
    end
    step(1'b1, FE, 16'h0);
    bad += (dvo !== 1'b0 || dtypeo !== '0 || datao !== '0) ? 1 : 0;
    total_cnt++;
    if (bad != 0 || out_rows !== '0)
      $display("FAIL post_reset_quiet: got %0d nonzero output words, out_rows=%0d, expected 0 and 0", bad, out_rows);
    else pass_cnt++;
  endtask
  initial begin
    test_reset();
    test_frame("crop_8x6", 1'b1, 2, 1, 3, 4, 8, 6, 1'b1, 1'b1, -1, 3, 4);
    test_frame("passthrough", 1'b0, 2, 1, 3, 4, 8, 6, 1'b1, 1'b1, -1, 8, 6);
    test_frame("implicit_rows", 1'b1, 0, 0, 0, 0, 8, 6, 1'b0, 1'b0, -1, 8, 6);
    test_header_wait();
    test_reset_midframe();
    test_frame("after_reset", 1'b1, 1, 2, 2, 3, 8, 6, 1'b1, 1'b1, -1, 2, 3);
    test_frame("offset_beyond", 1'b1, 10, 0, 0, 0, 8, 6, 1'b1, 1'b1, -1, 0, 0);
    test_frame("midframe_change", 1'b1, 0, 0, 0, 2, 8, 6, 1'b1, 1'b1, 5, 8, 2);
    test_frame("next_frame", 1'b1, 0, 0, 0, 5, 8, 6, 1'b1, 1'b1, -1, 8, 5);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
